// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder.
// Holds the SPI opcodes, command/address field widths and the responder FSM state type.
package spi_mem_pkg;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  localparam int unsigned CMD_BITS        = 8;
  localparam int unsigned ADDR_FIELD_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ_DATA,
    WRITE_DATA,
    IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end for the SPI pins.
// Each of sclk, cs and mosi passes through SYNC_STAGES flip-flops in the clk domain,
// then sclk is edge-detected against its own delayed copy.
// Ports:
//   clk                  system clock
//   sclk, cs, mosi       raw SPI pins from the master
//   sclk_rise/sclk_fall  one-clk pulses on synchronized sclk edges
//   cs_s, mosi_s         synchronized chip select and data
// The synchronizer flops carry no reset: they only ever hold pin samples, and
// leaving them alone lets the FSM see the true cs level straight out of reset.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   sclk_s;

  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sclk_q    <= sclk_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder (target side of the fetch master).
// Accepts READ (0x03) / WRITE (0x02) + 24-bit address and streams bytes from / into a
// 2**ADDR_BITS byte RAM. A host backdoor port preloads and inspects the RAM.
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   sclk, cs, mosi, miso       SPI pins (cs active low, MSB first)
//   host_we/addr/wdata/rdata   backdoor RAM port, rdata registered one clk
//   busy                       synchronized cs is low
//   wr_strobe                  one-clk pulse per byte committed by an SPI write
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata,
  output logic                 busy,
  output logic                 wr_strobe
);

  // Wide enough for a command byte and for the low address bits, nothing more.
  localparam int unsigned ShW = (ADDR_BITS > 8) ? ADDR_BITS - 1 : 7;

  localparam logic [4:0] CmdLast  = 5'(CMD_BITS - 1);
  localparam logic [4:0] AddrLast = 5'(ADDR_FIELD_BITS - 1);
  localparam logic [4:0] ByteLast = 5'd7;
  localparam logic [4:0] ByteDone = 5'd8;

  logic sclk_rise, sclk_fall, cs_s, mosi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_s     (cs_s),
    .mosi_s   (mosi_s)
  );

  logic [7:0]           mem [0:(1 << ADDR_BITS) - 1];

  spi_state_e           state_q;
  logic [4:0]           bit_cnt_q;
  logic [ShW-1:0]       shift_q;
  logic [ADDR_BITS-1:0] addr_ptr_q;
  logic [6:0]           tx_rest_q;   // bits still to go out after the one on miso
  logic                 is_read_q;
  logic                 fall_armed_q; // a fall only shifts after a rise in the data phase
  logic                 cs_q;

  logic [ShW-1:0]       shift_in;
  logic [7:0]           in_byte;
  logic [ADDR_BITS-1:0] addr_new;
  logic [ADDR_BITS-1:0] addr_inc;
  logic                 spi_commit;

  always_comb begin
    shift_in   = {shift_q[ShW-2:0], mosi_s};
    in_byte    = {shift_q[6:0], mosi_s};
    addr_new   = {shift_q[ADDR_BITS-2:0], mosi_s};
    addr_inc   = addr_ptr_q + 1'b1;
    spi_commit = rst_n && !cs_s && (state_q == WRITE_DATA) && sclk_rise &&
                 (bit_cnt_q == ByteLast);
  end

  // Host write first, SPI write second: on an address collision the SPI byte lands.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (spi_commit) mem[addr_ptr_q] <= in_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) host_rdata <= 8'h00;
    else        host_rdata <= mem[host_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_ptr_q   <= '0;
      tx_rest_q    <= '0;
      is_read_q    <= 1'b0;
      fall_armed_q <= 1'b0;
      cs_q         <= 1'b0; // cs already low at release must not look like a fresh fall
      miso         <= 1'b0;
      busy         <= 1'b0;
      wr_strobe    <= 1'b0;
    end else begin
      cs_q      <= cs_s;
      busy      <= ~cs_s;
      wr_strobe <= 1'b0;
      if (cs_s) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        fall_armed_q <= 1'b0;
        miso         <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            state_q   <= cs_q ? CMD : IGNORE;
          end
          CMD: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              if (bit_cnt_q == CmdLast) begin
                bit_cnt_q <= '0;
                if (in_byte == SPI_OP_READ) begin
                  state_q   <= ADDR;
                  is_read_q <= 1'b1;
                end else if (in_byte == SPI_OP_WRITE) begin
                  state_q   <= ADDR;
                  is_read_q <= 1'b0;
                end else begin
                  state_q <= IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              if (bit_cnt_q == AddrLast) begin
                bit_cnt_q  <= '0;
                addr_ptr_q <= addr_new;
                if (is_read_q) begin
                  // First data bit must be on miso before the master's next rise.
                  state_q      <= READ_DATA;
                  miso         <= mem[addr_new][7];
                  tx_rest_q    <= mem[addr_new][6:0];
                  fall_armed_q <= 1'b0;
                end else begin
                  state_q <= WRITE_DATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          READ_DATA: begin
            if (sclk_rise) begin
              fall_armed_q <= 1'b1;
              bit_cnt_q    <= bit_cnt_q + 5'd1;
            end else if (sclk_fall && fall_armed_q) begin
              fall_armed_q <= 1'b0;
              if (bit_cnt_q == ByteDone) begin
                bit_cnt_q  <= '0;
                addr_ptr_q <= addr_inc;
                miso       <= mem[addr_inc][7];
                tx_rest_q  <= mem[addr_inc][6:0];
              end else begin
                miso      <= tx_rest_q[6];
                tx_rest_q <= {tx_rest_q[5:0], 1'b0};
              end
            end
          end
          WRITE_DATA: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              if (bit_cnt_q == ByteLast) begin
                bit_cnt_q  <= '0;
                addr_ptr_q <= addr_inc;
                wr_strobe  <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          IGNORE: miso <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: an SPI master model drives transactions,
// a byte-array reference memory predicts results, and monitors compare DUT output
// (miso bytes, host readback, wr_strobe count) against queued expectations.
module tb_spi_mem_responder;

  localparam int unsigned AB    = 8;
  localparam int unsigned DEPTH = 1 << AB;
  localparam int unsigned HALF  = 8;  // sclk half period in clk cycles (clk/16)

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          host_we = 1'b0;
  logic [AB-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'h00;
  logic          miso;
  logic [7:0]    host_rdata;
  logic          busy;
  logic          wr_strobe;

  always #5 clk = ~clk;

  spi_mem_responder #(
    .ADDR_BITS  (AB),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .busy      (busy),
    .wr_strobe (wr_strobe)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_host[$];
  int          strobe_cnt = 0;
  int          exp_strobe = 0;
  logic        rd_phase = 1'b0;
  logic        hr_req = 1'b0;
  logic        zero_chk = 1'b0;
  int          miso_hi = 0;
  logic [7:0]  rd_sh = 8'h00;
  int          rd_n = 0;
  logic [31:0] rd_word = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: master samples miso on each sclk rise during the data phase.
  always @(posedge sclk) begin
    if (zero_chk && miso !== 1'b0) miso_hi++;
    if (rd_phase) begin
      rd_sh = {rd_sh[6:0], miso};
      rd_n++;
      if (rd_n == 8) begin
        rd_n    = 0;
        rd_word = {rd_word[23:0], rd_sh};
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL read byte: got 0x%0h with no byte expected", rd_sh);
        end else begin
          check("read byte", 32'(rd_sh), 32'(exp_rd.pop_front()));
        end
      end
    end else begin
      rd_n = 0;
    end
  end

  // Host readback monitor.
  always @(posedge clk) begin
    logic [7:0] e;
    if (hr_req) begin
      e = exp_host.pop_front();
      #1;
      check("host readback", 32'(host_rdata), 32'(e));
    end
  end

  always @(posedge clk) begin
    #1;
    if (wr_strobe) strobe_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    @(negedge clk);
    host_addr  = AB'(a);
    host_wdata = d;
    host_we    = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input int a);
    @(negedge clk);
    host_addr = AB'(a);
    exp_host.push_back(ref_mem[a]);
    hr_req = 1'b1;
    @(negedge clk);
    hr_req = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    tick(HALF);
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    cs = 1'b1;
    tick(HALF);
  endtask

  task automatic spi_header(input logic [7:0] op, input logic [23:0] a);
    cs_begin();
    send_byte(op);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    spi_header(8'h03, a);
    for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    rd_phase = 1'b1;
    repeat (n * 8) spi_bit(1'($urandom));
    rd_phase = 1'b0;
    cs_end();
    check("read bytes drained", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic spi_write(input logic [23:0] a, input logic [7:0] data[$], input int extra);
    spi_header(8'h02, a);
    for (int i = 0; i < data.size(); i++) begin
      send_byte(data[i]);
      ref_mem[(int'(a) + i) % DEPTH] = data[i];
      exp_strobe++;
    end
    repeat (extra) spi_bit(1'($urandom));
    cs_end();
    check("wr_strobe count", 32'(strobe_cnt), 32'(exp_strobe));
  endtask

  task automatic spi_junk(input logic [7:0] op, input int nbits);
    miso_hi  = 0;
    zero_chk = 1'b1;
    cs_begin();
    check("busy in transaction", 32'(busy), 32'd1);
    send_byte(op);
    repeat (nbits) spi_bit(1'($urandom));
    zero_chk = 1'b0;
    cs_end();
    check("miso quiet on bad opcode", 32'(miso_hi), 32'd0);
    check("busy after cs high", 32'(busy), 32'd0);
    check("no strobe on bad opcode", 32'(strobe_cnt), 32'(exp_strobe));
  endtask

  // Host hammers an address every clk until the SPI byte commits.
  task automatic collide(input logic [7:0] a, input bit same);
    logic [7:0] sb = 8'($urandom);
    logic [7:0] hv = 8'($urandom);
    logic [7:0] hb = same ? a : (a ^ 8'h5A);
    logic [7:0] q[$];
    q.push_back(sb);
    fork
      spi_write({16'h0, a}, q, 0);
      begin
        int seen = 0;
        for (int i = 0; i < 4000 && seen == 0; i++) begin
          @(negedge clk);
          if (wr_strobe) begin
            seen = 1;
          end else begin
            host_addr  = hb;
            host_wdata = hv;
            host_we    = 1'b1;
          end
        end
        host_we = 1'b0;
        if (!same) ref_mem[hb] = hv;
        check("collision strobe seen", 32'(seen), 32'd1);
      end
    join
    host_read(int'(a));
    host_read(int'(hb));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] op;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    // Reset values, sampled while reset is held.
    tick(5);
    check("reset miso", 32'(miso), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset host_rdata", 32'(host_rdata), 32'd0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < DEPTH; i++) host_write(i, 8'($urandom));

    // Preloaded word read.
    host_write(8'h10, 8'hDE);
    host_write(8'h11, 8'hAD);
    host_write(8'h12, 8'hBE);
    host_write(8'h13, 8'hEF);
    spi_read(24'h000010, 4);
    check("word at 0x10", rd_word, 32'hDEADBEEF);

    // Three-byte write, host readback.
    q = {8'h11, 8'h22, 8'h33};
    spi_write(24'h000020, q, 0);
    for (int i = 8'h20; i <= 8'h22; i++) host_read(i);
    check("mem[0x21] model", 32'(ref_mem[8'h21]), 32'h22);

    // Wrap, with and without upper address bits.
    spi_read(24'h0000FE, 4);
    spi_read(24'hAB00FE, 4);

    // Partial trailing byte never commits.
    q = {8'h55};
    spi_write(24'h000030, q, 5);
    host_read(8'h30);
    host_read(8'h31);

    spi_junk(8'h9F, 32);

    // Reset in the middle of a read data phase.
    spi_header(8'h03, 24'h000040);
    repeat (4) spi_bit(1'b0);
    tick(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("miso after mid-read reset", 32'(miso), 32'd0);
    check("busy after mid-read reset", 32'(busy), 32'd0);
    tick(3);
    check("miso while cs held after reset", 32'(miso), 32'd0);
    cs = 1'b1;
    tick(HALF);
    spi_read(24'h000040, 4);

    collide(8'h50, 1'b1);
    collide(8'h60, 1'b0);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0, 1: spi_read(24'($urandom), int'($urandom_range(1, 5)));
        2: begin
          q.delete();
          repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
          spi_write(24'($urandom), q, int'($urandom_range(0, 7)));
        end
        default: begin
          op = 8'($urandom);
          while (op == 8'h02 || op == 8'h03) op = 8'($urandom);
          spi_junk(op, int'($urandom_range(0, 24)));
        end
      endcase
      if ($urandom_range(0, 1) == 1) host_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
    end

    for (int i = 0; i < DEPTH; i++) host_read(i);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
